inst_stream_driver: RTL and testbench

- Parametrised instruction/data stream source that feeds the `main` CPU core's `inst` and `in_bus` inputs from an internal program buffer.
- It replaces hand-timed stimulus with a loadable program, so directed instruction sequences (LUI, JAL, JALR, AUIPC, ...) run reproducibly.
- Two issue modes: fixed cycles-per-instruction, or a valid/ready handshake with the core.
- Also provides looping, a halt sentinel, abort, and issue accounting.

---
 rtl/inst_stream_driver_if.sv | 29 ++
 rtl/inst_stream_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_inst_stream_driver.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_stream_driver_if.sv
// Instruction/data bus between inst_stream_driver and the core it feeds.
//   master (driver side): drives inst, in_bus, inst_valid, pc; samples cpu_ready
//   slave  (core side)  : samples inst, in_bus, inst_valid, pc; drives cpu_ready
`timescale 1ns/1ps
interface inst_stream_driver_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] in_bus;
  logic [XLEN-1:0] pc;
  logic            inst_valid;
  logic            cpu_ready;

  modport master (
    output inst,
    output in_bus,
    output inst_valid,
    output pc,
    input  cpu_ready
  );

  modport slave (
    input  inst,
    input  in_bus,
    input  inst_valid,
    input  pc,
    output cpu_ready
  );
endinterface

// File: rtl/inst_stream_driver.sv
// Loadable instruction/data stream source for the core's inst and in_bus inputs.
// Entries are written into a program buffer while idle, then issued either with
// a fixed hold of CPI cycles each or under a valid/ready handshake. Supports
// looping, a halt sentinel word, abort and a saturating issue counter.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load_en/addr/inst/data  buffer write port (accepted in IDLE/DONE only)
//   prog_len       entries to run (1..DEPTH), sampled on start
//   start          begin issuing from entry 0 (ignored while issuing)
//   mode           0 = fixed CPI, 1 = handshake, sampled on start
//   loop_en        wrap to entry 0 after the last entry (checked at each advance)
//   abort          return to IDLE next cycle, highest priority after rst
//   bus            master side of inst_stream_driver_if (inst, in_bus, pc,
//                  inst_valid out; cpu_ready in)
//   busy           issuing in progress
//   done           program finished; held until start, abort or rst
//   issue_count    completed instructions since start, saturating
//   load_err       sticky flag: write attempted while issuing
`timescale 1ns/1ps
module inst_stream_driver #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 64,
  parameter int              ADDR_W    = 6,
  parameter int              CPI       = 4,
  parameter logic [XLEN-1:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [XLEN-1:0]       load_inst,
  input  logic [XLEN-1:0]       load_data,
  input  logic [ADDR_W:0]       prog_len,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  loop_en,
  input  logic                  abort,
  inst_stream_driver_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           issue_count,
  output logic                  load_err
);

  localparam int                CYC_W    = (CPI > 1) ? $clog2(CPI) : 1;
  localparam logic [CYC_W-1:0]  CPI_LAST = CYC_W'(CPI - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] idx_q, idx_nx;
  logic [CYC_W-1:0]  cyc_q, cyc_nx;
  logic              mode_q, mode_nx;
  logic [ADDR_W:0]   len_q, len_nx;
  logic [XLEN-1:0]   inst_q, inst_nx;
  logic [XLEN-1:0]   data_q, data_nx;
  logic [XLEN-1:0]   pc_q, pc_nx;
  logic              vld_q, vld_nx;
  logic              done_q, done_nx;
  logic [15:0]       cnt_q, cnt_nx;
  logic              err_q, err_nx;

  logic [XLEN-1:0]   mem_inst [DEPTH];
  logic [XLEN-1:0]   mem_data [DEPTH];

  logic              present;
  logic              finish;
  logic              complete;
  logic [ADDR_W-1:0] fetch_idx;
  logic [XLEN-1:0]   fetch_inst;
  logic [XLEN-1:0]   fetch_data;
  logic              len_ok;
  logic              last;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Program buffer: contents survive reset, writes blocked while issuing
  always_ff @(posedge clk) begin
    if (load_en && (state_q != ISSUE)) begin
      mem_inst[load_addr] <= load_inst;
      mem_data[load_addr] <= load_data;
    end
  end

  assign len_ok = (prog_len != '0) && (prog_len <= DEPTH_L);
  assign last   = ({1'b0, idx_q} == (len_q - 1'b1));

  // Next-state / output decode
  always_comb begin
    state_nx   = state_q;
    idx_nx     = idx_q;
    cyc_nx     = cyc_q;
    mode_nx    = mode_q;
    len_nx     = len_q;
    inst_nx    = inst_q;
    data_nx    = data_q;
    pc_nx      = pc_q;
    vld_nx     = vld_q;
    done_nx    = done_q;
    cnt_nx     = cnt_q;
    err_nx     = err_q;
    present    = 1'b0;
    finish     = 1'b0;
    complete   = 1'b0;
    fetch_idx  = '0;
    fetch_inst = '0;
    fetch_data = '0;

    if (abort) begin
      state_nx = IDLE;
      vld_nx   = 1'b0;
      inst_nx  = '0;
      data_nx  = '0;
      pc_nx    = '0;
      done_nx  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            err_nx = 1'b0;
            cnt_nx = '0;
            if (len_ok) begin
              mode_nx = mode;
              len_nx  = prog_len;
              present = 1'b1;
            end else begin
              finish = 1'b1;
            end
          end
        end
        ISSUE: begin
          complete = mode_q ? bus.cpu_ready : (cyc_q == CPI_LAST);
          if (complete) begin
            cnt_nx = sat_inc(cnt_q);
            if (!last) begin
              present   = 1'b1;
              fetch_idx = idx_q + 1'b1;
            end else if (loop_en) begin
              present = 1'b1;
            end else begin
              finish = 1'b1;
            end
          end else if (!mode_q) begin
            cyc_nx = cyc_q + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // A sentinel word ends the program instead of being presented
    fetch_inst = mem_inst[fetch_idx];
    fetch_data = mem_data[fetch_idx];
    if (present) begin
      if (fetch_inst == HALT_INST) begin
        finish = 1'b1;
      end else begin
        state_nx = ISSUE;
        idx_nx   = fetch_idx;
        cyc_nx   = '0;
        inst_nx  = fetch_inst;
        data_nx  = fetch_data;
        pc_nx    = XLEN'({fetch_idx, 2'b00});
        vld_nx   = 1'b1;
        done_nx  = 1'b0;
      end
    end

    if (finish) begin
      state_nx = DONE;
      vld_nx   = 1'b0;
      inst_nx  = '0;
      data_nx  = '0;
      pc_nx    = '0;
      done_nx  = 1'b1;
    end

    if (load_en && (state_q == ISSUE)) begin
      err_nx = 1'b1;
    end
  end

  // State and presented-entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      mode_q  <= 1'b0;
      len_q   <= '0;
      inst_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      cyc_q   <= cyc_nx;
      mode_q  <= mode_nx;
      len_q   <= len_nx;
      inst_q  <= inst_nx;
      data_q  <= data_nx;
      pc_q    <= pc_nx;
      vld_q   <= vld_nx;
      done_q  <= done_nx;
      cnt_q   <= cnt_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.inst       = inst_q;
  assign bus.in_bus     = data_q;
  assign bus.pc         = pc_q;
  assign bus.inst_valid = vld_q;
  assign busy           = (state_q == ISSUE);
  assign done           = done_q;
  assign issue_count    = cnt_q;
  assign load_err       = err_q;

endmodule

// File: tb/tb_inst_stream_driver.sv
// Scoreboard bench for inst_stream_driver: stimulus pushes the expected issued
// entries into a queue; a negedge monitor compares every presented word.
`timescale 1ns/1ps
module tb_inst_stream_driver;
  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 64;
  localparam int          ADDR_W = 6;
  localparam int          CPI    = 4;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] data;
    logic [31:0] pc;
    int          hold;
  } item_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [XLEN-1:0]   load_inst;
  logic [XLEN-1:0]   load_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              mode;
  logic              loop_en;
  logic              abort;
  logic              busy;
  logic              done;
  logic [15:0]       issue_count;
  logic              load_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_inst [DEPTH];
  logic [31:0] m_data [DEPTH];
  item_t       exp_q [$];
  int          seen = 0;
  bit          cur_mode = 1'b0;

  always #5 clk = ~clk;

  inst_stream_driver_if #(.XLEN(XLEN)) bus ();

  inst_stream_driver #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CPI(CPI), .HALT_INST(HALT)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_inst(load_inst), .load_data(load_data), .prog_len(prog_len),
    .start(start), .mode(mode), .loop_en(loop_en), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .issue_count(issue_count), .load_err(load_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each presented word with the head of the expected queue
  always @(negedge clk) begin
    if (bus.inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(bus.inst_valid), 64'd0);
      end else begin
        check("inst", bus.inst, exp_q[0].inst);
        check("in_bus", bus.in_bus, exp_q[0].data);
        check("pc", bus.pc, exp_q[0].pc);
        seen++;
        if (cur_mode ? (bus.cpu_ready === 1'b1) : (seen == exp_q[0].hold)) begin
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end else if (seen != 0) begin
      check("hold_len", 64'(seen), 64'(exp_q[0].hold));
      void'(exp_q.pop_front());
      seen = 0;
    end
  end

  task automatic load(input int a, input logic [31:0] i, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_inst = i;
    load_data = d;
    @(posedge clk); #1;
    load_en   = 1'b0;
    m_inst[a] = i;
    m_data[a] = d;
  endtask

  task automatic pulse_start(input int len, input bit md);
    cur_mode = md;
    mode     = md;
    prog_len = (ADDR_W + 1)'(len);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Expected stream: entries in order until the first sentinel or the end
  task automatic run_prog(input int len, input bit md, input int low, input int pct, input bit bad_load);
    int n = 0;
    int k = 0;
    bit r;
    for (int i = 0; i < len; i++) begin
      if (m_inst[i] == HALT) break;
      exp_q.push_back('{m_inst[i], m_data[i], 32'(i * 4), CPI});
      n++;
    end
    loop_en = 1'b0;
    pulse_start(len, md);
    while (done !== 1'b1 && k < 4000) begin
      r = ($urandom_range(99) < pct);
      bus.cpu_ready = md ? ((k >= low) && r) : 1'($urandom_range(1));
      load_en = bad_load && (k == 2);
      load_addr = '0;
      load_inst = ~m_inst[0];
      load_data = ~m_data[0];
      @(posedge clk); #1;
      k++;
    end
    load_en = 1'b0;
    bus.cpu_ready = 1'b0;
    check("done", 64'(done), 64'd1);
    if (!md) check("run_cycles", 64'(k), 64'(n * CPI));
    check("issue_count", 64'(issue_count), 64'(n));
    check("end_valid", 64'(bus.inst_valid), 64'd0);
    check("end_inst", bus.inst, 64'd0);
    check("end_in_bus", bus.in_bus, 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("load_err", 64'(load_err), 64'(bad_load));
    check("pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_loop(input int len, input int passes);
    int total = len * passes;
    int k = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++)
        exp_q.push_back('{m_inst[i], m_data[i], 32'(i * 4), 1});
    loop_en = 1'b1;
    bus.cpu_ready = 1'b1;
    pulse_start(len, 1'b1);
    repeat (total - 1) @(posedge clk);
    #1;
    loop_en = 1'b0;
    while (done !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    bus.cpu_ready = 1'b0;
    check("loop_done", 64'(done), 64'd1);
    check("loop_tail", 64'(k), 64'd1);
    check("loop_count", 64'(issue_count), 64'(total));
    check("loop_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Interrupt the run during the first cycle of entry 2 with abort or rst
  task automatic run_cut(input bit use_rst);
    for (int i = 0; i < 2; i++) exp_q.push_back('{m_inst[i], m_data[i], 32'(i * 4), CPI});
    exp_q.push_back('{m_inst[2], m_data[2], 32'd8, 1});
    loop_en = 1'b0;
    pulse_start(4, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    abort = 1'b0;
    check("cut_valid", 64'(bus.inst_valid), 64'd0);
    check("cut_inst", bus.inst, 64'd0);
    check("cut_in_bus", bus.in_bus, 64'd0);
    check("cut_done", 64'(done), 64'd0);
    check("cut_busy", 64'(busy), 64'd0);
    check("cut_count", 64'(issue_count), use_rst ? 64'd0 : 64'd2);
    if (use_rst) check("cut_pc", bus.pc, 64'd0);
    check("cut_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bad_len(input int len, input int held_cnt);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_done", 64'(done), 64'd0);
    check("abort_count", 64'(issue_count), 64'(held_cnt));
    pulse_start(len, 1'b0);
    check("badlen_done", 64'(done), 64'd1);
    check("badlen_valid", 64'(bus.inst_valid), 64'd0);
    check("badlen_count", 64'(issue_count), 64'd0);
    check("badlen_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int len;
    bit md;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_inst = '0; load_data = '0;
    prog_len = '0; start = 1'b0; mode = 1'b0; loop_en = 1'b0; abort = 1'b0;
    bus.cpu_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_inst", bus.inst, 64'd0);
    check("rst_in_bus", bus.in_bus, 64'd0);
    check("rst_pc", bus.pc, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(issue_count), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    rst = 1'b0;

    // LUI x1 then JAL x1, fixed CPI
    load(0, 32'h1234A0B7, 32'd58);
    load(1, 32'h008000EF, 32'd58);
    run_prog(2, 1'b0, 0, 100, 1'b0);

    // Handshake with five cycles of back-pressure on entry 0
    load(0, 32'h00100093, 32'h11);
    load(1, 32'h00200113, 32'h22);
    load(2, 32'h00000097, 32'h33);
    run_prog(3, 1'b1, 5, 100, 1'b0);

    // Looping A B C twice, then stop after C
    load(0, 32'hA0A0_0001, 32'h1);
    load(1, 32'hB0B0_0002, 32'h2);
    load(2, 32'hC0C0_0003, 32'h3);
    run_loop(3, 2);

    // Sentinel at entry 1
    load(1, HALT, 32'h0);
    run_prog(3, 1'b0, 0, 100, 1'b0);

    // Abort and reset during entry 2
    for (int i = 0; i < 4; i++) load(i, 32'h0000_0013 + 32'(i << 7), 32'(100 + i));
    run_cut(1'b0);
    run_cut(1'b1);

    // Write while issuing is dropped and flagged; readback run shows entry 0 intact
    load(0, 32'h0040_006F, 32'h5A);
    load(1, 32'h0000_8067, 32'hA5);
    run_prog(2, 1'b0, 0, 100, 1'b1);
    run_prog(2, 1'b1, 0, 70, 1'b0);

    // Out-of-range lengths
    bad_len(0, 2);
    bad_len(DEPTH + 1, 0);

    // Randomized programs
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 10);
      md  = 1'($urandom_range(1));
      for (int i = 0; i < len; i++)
        load(i, ($urandom_range(7) == 0) ? HALT : $urandom, $urandom);
      run_prog(len, md, 0, $urandom_range(30, 100), 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
